out_port: RTL and testbench
===========================

# out_port

Read-side output port of the switch: the egress mirror of the per-port write path. It accepts ECC-corrected 128-bit pages from the read pipeline (after `ecc_decoder`) and serializes them into 16-bit words on the external `rd_sop/rd_eop/rd_vld/rd_data` interface. It uses the packet length in the header word to frame the packet and discards any page tail past end-of-packet. One instance sits on each of the 16 output ports, alongside `controller`.

## Interface
- `DW`, 16: output word width.
- `PW`, 8: words per page; a page is `DW*PW` = 128 bits.
- `clk` in 1: clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `ready` in 1: downstream device can take a packet; sampled only at packet start.
- `page_vld` in 1: page offered by the read pipeline.
- `page_last` in 1: offered page is the final page of its packet.
- `page_data` in 128: corrected page; word 0 is `[127:112]`, word 7 is `[15:0]`.
- `page_rdy` out 1: block accepts the page this cycle (`page_vld & page_rdy` = transfer).
- `rd_sop` out 1: one-cycle start-of-packet strobe.
- `rd_vld` out 1: `rd_data` valid.
- `rd_eop` out 1: last word; coincides with `rd_vld`.
- `rd_data` out 16: output word.
- `len_err` out 1: sticky; header length disagreed with `page_last` framing.

## Operation
- Two-slot page buffer, ping-pong. `cnt` (0..2) counts full slots; `wp`/`rp` are 1-bit slot pointers.
- `fetch_done` is set when a page with `page_last` is accepted. It clears on entry to IDLE after eop.
- `page_rdy = (cnt != 2) & ~fetch_done`. In DRAIN, `page_rdy = 1` and accepted pages are discarded.
- Header word (word 0 of the first page):
  - `[3:0]` dest port, `[6:4]` priority: ignored here.
  - `[15:7]` = `len` = payload words. Total words = `len + 1`, range 1..512.
- Word counter: 10 bits, counts emitted words. Page word index `wi`: 3 bits, wraps 7→0.
- FSM:
  - **IDLE**
    - `cnt >= 1 & ready` → SOP.
    - Pages may be prefetched (up to 2, until `page_last`) while idle.
  - **SOP**
    - `rd_sop = 1` for exactly this cycle.
    - → DATA.
  - **DATA**
    - Each cycle with `cnt >= 1`: emit word `wi` of slot `rp` with `rd_vld = 1`, then `wi++`.
    - When `wi == 7` is emitted, the slot is freed (`cnt--`, `rp` toggles).
    - With `cnt == 0`: `rd_vld = 0` (bubble). Bubbles are legal; no timeout.
    - Latch `len` from word 0 when it is emitted.
    - Eop is the word where the counter reaches `len + 1`:
      - assert `rd_eop` on it;
      - free the current slot regardless of `wi` (tail words dropped);
      - reset `wi`.
    - If that slot was not a `page_last` page → set `len_err`, go to DRAIN. Otherwise → IDLE.
    - Forced eop: a `page_last` page's word 7 is emitted before length is reached → assert `rd_eop` there, set `len_err`, go to IDLE.
  - **DRAIN**
    - Discard buffered and incoming pages up to and including the `page_last` page → IDLE.
- Simultaneous page accept and slot free in one cycle: `cnt` unchanged; both pointers advance.
- `ready` falling mid-packet is ignored. Packets are never truncated by `ready`.
- `len_err` clears only on reset.

## Timing
- Reset values: all outputs 0. `rd_data = 16'h0`, `page_rdy = 1` one cycle after reset release (combinational from cleared state). FSM in IDLE, `cnt = 0`, flags clear.
- Reset mid-packet: outputs drop immediately (async). No eop is emitted; buffered pages are lost.
- Outputs `rd_*` are registered.
- Start latency: IDLE condition true at edge N → `rd_sop` high in cycle N+1 → first `rd_vld` (header) in cycle N+2.
- Steady state: 1 word/cycle. No bubble at a page boundary when the other slot is full.
- Accepted page: usable for output the cycle after acceptance.
- Minimum gap: `rd_eop` in cycle M → next `rd_sop` no earlier than M+2.
- `rd_sop` and `rd_vld` are never high in the same cycle.

## Test plan
- Header `len=15`, 2 pages (second `page_last`), `ready=1`:
  - `rd_sop` once, then 16 consecutive `rd_vld` words in page order;
  - `rd_eop` with word 15; `len_err = 0`.
- Header `len=3`, single `page_last` page:
  - 4 words, eop on the 4th; words 4–7 never appear;
  - `page_rdy` returns 1 after IDLE entry.
- `len=15`, second page delivered 5 cycles late:
  - 8 words, `rd_vld` low 5 cycles, then 8 words;
  - no eop until word 15.
- Page buffered with `ready=0` for 10 cycles → no `rd_sop`. Raise `ready` → `rd_sop` next cycle, header the cycle after.
- Framing mismatch, two cases:
  - `len=20`, `page_last` on page 2 → `rd_eop` forced on word 15, `len_err = 1`;
  - separate run: `len=3`, `page_last` on page 2 → eop on word 3, page 2 discarded via DRAIN, `len_err = 1`.
- Assert `rst_n = 0` during word 10 of a 16-word packet:
  - all outputs 0 immediately;
  - after release, a fresh `len=0` packet emits exactly `rd_sop` then one word with `rd_eop`.

Source files
------------

// File: rtl/out_port.sv
// out_port: read-side egress port of the switch.
//
// Accepts ECC-corrected 128-bit pages from the read pipeline into a two-slot
// ping-pong buffer and serializes them as 16-bit words on the rd_* interface.
// Packet framing comes from the 9-bit length field in the header word; any
// page tail past end-of-packet is dropped. If the length field and the
// page_last framing disagree, the sticky len_err flag is raised.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ready               downstream can take a packet (sampled at packet start)
//   page_vld/page_last  page offered / page is the final page of its packet
//   page_data[127:0]    page, word 0 in [127:112], word 7 in [15:0]
//   page_rdy            page accepted this cycle when page_vld is high
//   rd_sop              one-cycle start-of-packet strobe (registered)
//   rd_vld/rd_eop       word valid / last word of packet (registered)
//   rd_data[15:0]       output word (registered, zero when not valid)
//   len_err             sticky header-length vs page framing mismatch
module out_port #(
  parameter int DW = 16,
  parameter int PW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready,
  input  logic              page_vld,
  input  logic              page_last,
  input  logic [DW*PW-1:0]  page_data,
  output logic              page_rdy,
  output logic              rd_sop,
  output logic              rd_vld,
  output logic              rd_eop,
  output logic [DW-1:0]     rd_data,
  output logic              len_err
);

  localparam int WIW = $clog2(PW);
  localparam int LW  = 9;
  localparam int CW  = LW + 1;
  localparam logic [WIW-1:0] WI_LAST = WIW'(PW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SOP   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [DW*PW-1:0] slot_mem [2];
  logic [1:0]       slot_last;
  logic [1:0]       cnt;
  logic             wp, rp;
  logic             fetch_done;
  logic             run;
  logic [WIW-1:0]   wi;
  logic [CW-1:0]    wcnt;
  logic [LW-1:0]    len_q;

  logic             accept, store, emit, last_word, len_hit, forced;
  logic             eop, free, short_pkt, flush;
  logic [DW-1:0]    cur_word;
  logic [LW-1:0]    len_cur;
  logic             sop_nx, vld_nx, eop_nx;
  logic [DW-1:0]    data_nx;

  // run holds page_rdy low until the first clock after reset release.
  // Once the final page of a packet has been taken nothing further belongs
  // to it, so the buffer stays closed (DRAIN included) until IDLE re-entry.
  assign page_rdy = run & ~fetch_done & ((state == DRAIN) | (cnt != 2'd2));
  assign accept   = page_vld & page_rdy;
  // Pages accepted while draining belong to the aborted packet: never stored.
  assign store    = accept & (state != DRAIN);

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < PW; i++) begin
      if (wi == WIW'(i)) cur_word = slot_mem[rp][(PW-1-i)*DW +: DW];
    end
  end

  // SOP is the cycle rd_sop is visible; the header is fetched during it so
  // that the first word follows the strobe directly.
  assign emit      = ((state == SOP) | (state == DATA)) & (cnt != 2'd0);
  // The header word carries its own length before len_q has captured it.
  assign len_cur   = (wcnt == '0) ? cur_word[DW-1 -: LW] : len_q;
  assign len_hit   = emit & (wcnt == {1'b0, len_cur});
  assign last_word = emit & (wi == WI_LAST);
  assign forced    = last_word & slot_last[rp] & ~len_hit;
  assign eop       = len_hit | forced;
  assign free      = last_word | len_hit;
  assign short_pkt = len_hit & ~slot_last[rp];
  assign flush     = (state_nx == DRAIN) | (state == DRAIN);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if ((cnt != 2'd0) & ready) state_nx = SOP;
      SOP,
      DATA: begin
        if (state == SOP) state_nx = DATA;
        if (eop)          state_nx = short_pkt ? DRAIN : IDLE;
      end
      DRAIN: if (fetch_done | (page_vld & page_last)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs (registered below)
  always_comb begin
    sop_nx  = (state_nx == SOP);
    vld_nx  = emit;
    eop_nx  = eop;
    data_nx = emit ? cur_word : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      cnt        <= 2'd0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      slot_last  <= 2'b00;
      fetch_done <= 1'b0;
      wi         <= '0;
      wcnt       <= '0;
      len_err    <= 1'b0;
      rd_sop     <= 1'b0;
      rd_vld     <= 1'b0;
      rd_eop     <= 1'b0;
      rd_data    <= '0;
    end else begin
      run <= 1'b1;
      if (store) slot_last[wp] <= page_last;

      // Draining discards every buffered page, including one stored on the
      // very cycle the short packet ended.
      if (flush) begin
        cnt <= 2'd0;
        wp  <= wp ^ store;
        rp  <= wp ^ store;
      end else begin
        cnt <= cnt + {1'b0, store} - {1'b0, free};
        wp  <= wp ^ store;
        rp  <= rp ^ free;
      end

      if ((state != IDLE) & (state_nx == IDLE)) fetch_done <= 1'b0;
      else if (store & page_last)               fetch_done <= 1'b1;

      if (state == IDLE) wcnt <= '0;
      else if (emit)     wcnt <= wcnt + CW'(1);

      if (eop)       wi <= '0;
      else if (emit) wi <= wi + WIW'(1);

      if (forced | short_pkt) len_err <= 1'b1;

      rd_sop  <= sop_nx;
      rd_vld  <= vld_nx;
      rd_eop  <= eop_nx;
      rd_data <= data_nx;
    end
  end

  // Page storage and the latched length need no reset.
  always_ff @(posedge clk) begin
    if (store) slot_mem[wp] <= page_data;
    if (emit & (wcnt == '0)) len_q <= cur_word[DW-1 -: LW];
  end

endmodule

// File: tb/tb_out_port.sv
module tb_out_port;
  localparam int DW = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ready = 1'b0;
  logic          page_vld = 1'b0;
  logic          page_last = 1'b0;
  logic [127:0]  page_data = '0;
  logic          page_rdy, rd_sop, rd_vld, rd_eop, len_err;
  logic [15:0]   rd_data;

  out_port #(.DW(DW), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .page_vld(page_vld), .page_last(page_last), .page_data(page_data),
    .page_rdy(page_rdy), .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_eop(rd_eop),
    .rd_data(rd_data), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: cumulative logs, never cleared.
  logic [15:0] got_q[$];
  int          vcyc_q[$];
  int          eop_pos_q[$];
  int          sop_cyc_q[$];
  int          viol = 0;
  int          last_eop = -100;

  always @(negedge clk) begin
    if (rd_sop) begin
      sop_cyc_q.push_back(cyc);
      if (rd_vld) viol++;
      if (cyc < last_eop + 2) viol++;
    end
    if (rd_vld) begin
      got_q.push_back(rd_data);
      vcyc_q.push_back(cyc);
      if (rd_eop) begin
        eop_pos_q.push_back(got_q.size() - 1);
        last_eop = cyc;
      end
    end else if (rd_eop) begin
      viol++;
    end
  end

  int    checks = 0;
  int    failures = 0;
  string ctx = "init";
  int    base_w, base_s, base_e, base_v;

  logic [127:0] pg_q[$];
  logic [15:0]  exp_q[$];

  typedef struct {
    int len;
    int np;
    int gap;
    int exp_n;
    int exp_err;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s %s: got %0d expected %0d", ctx, name, act, exp);
    end
  endtask

  task automatic snap();
    base_w = got_q.size();
    base_s = sop_cyc_q.size();
    base_e = eop_pos_q.size();
    base_v = viol;
  endtask

  task automatic do_reset();
    page_vld = 1'b0;
    page_last = 1'b0;
    ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Builds np pages whose first word is a header with the given length;
  // exp_q receives every word of every page in order.
  task automatic gen_pages(input int len, input int np);
    logic [127:0] p;
    logic [15:0]  w;
    logic [8:0]   l9;
    pg_q.delete();
    exp_q.delete();
    l9 = len[8:0];
    for (int i = 0; i < np; i++) begin
      p = '0;
      for (int j = 0; j < PW; j++) begin
        w = 16'($urandom);
        if (i == 0 && j == 0) w = {l9, w[6:0]};
        p[(PW-1-j)*DW +: DW] = w;
        exp_q.push_back(w);
      end
      pg_q.push_back(p);
    end
  endtask

  task automatic send_page(input logic [127:0] d, input logic last);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    page_vld = 1'b1;
    page_data = d;
    page_last = last;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = page_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    page_vld = 1'b0;
    page_last = 1'b0;
    if (!acc) chk("page_accept_budget", 0, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (eop_pos_q.size() == base_e && n < 6000) begin
      @(posedge clk);
      n++;
    end
    chk("eop_within_budget", int'(eop_pos_q.size() > base_e), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_pkt(input int len, input int np, input int maxgap, input int rdelay);
    snap();
    gen_pages(len, np);
    fork
      begin
        for (int i = 0; i < np; i++) begin
          automatic int g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
          if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
          end
          send_page(pg_q[i], (i == np - 1));
        end
      end
      begin
        if (rdelay > 0) begin
          ready = 1'b0;
          repeat (rdelay) @(posedge clk);
          #1;
        end
        ready = 1'b1;
      end
    join
    wait_done();
  endtask

  task automatic check_pkt(input int exp_n, input int exp_err);
    int nw, ns, ne, eidx, mism;
    nw = got_q.size() - base_w;
    ns = sop_cyc_q.size() - base_s;
    ne = eop_pos_q.size() - base_e;
    eidx = (ne > 0) ? eop_pos_q[base_e] - base_w : -1;
    mism = 0;
    for (int i = 0; i < nw && i < exp_q.size(); i++)
      if (got_q[base_w + i] != exp_q[i]) mism++;
    chk("sop_count", ns, 1);
    chk("word_count", nw, exp_n);
    chk("eop_count", ne, 1);
    chk("eop_index", eidx, exp_n - 1);
    chk("data_mismatches", mism, 0);
    chk("len_err", int'(len_err), exp_err);
    chk("protocol_violations", viol - base_v, 0);
    chk("page_rdy_after_idle", int'(page_rdy), 1);
  endtask

  initial begin
    int n, span, raise_cyc, len, np, n_ok, mode, exp_n, err_model;

    tbl[0]  = '{15,  2, 0,  16, 0};
    tbl[1]  = '{3,   1, 0,   4, 0};
    tbl[2]  = '{20,  2, 0,  16, 1};
    tbl[3]  = '{3,   2, 0,   4, 1};
    tbl[4]  = '{0,   1, 0,   1, 0};
    tbl[5]  = '{7,   1, 0,   8, 0};
    tbl[6]  = '{8,   1, 0,   8, 1};
    tbl[7]  = '{7,   2, 0,   8, 1};
    tbl[8]  = '{8,   2, 3,   9, 0};
    tbl[9]  = '{511, 64, 0, 512, 0};
    tbl[10] = '{100, 3, 2,  24, 1};
    tbl[11] = '{16,  4, 1,  17, 1};

    // Reset state
    ctx = "reset";
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rd_sop", int'(rd_sop), 0);
    chk("rd_vld", int'(rd_vld), 0);
    chk("rd_eop", int'(rd_eop), 0);
    chk("rd_data", int'(rd_data), 0);
    chk("len_err", int'(len_err), 0);
    chk("page_rdy_in_reset", int'(page_rdy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("page_rdy_after_release", int'(page_rdy), 1);

    // Table-driven packets, each from a clean reset
    for (int i = 0; i < 12; i++) begin
      do_reset();
      ctx = $sformatf("vec%0d_len%0d_np%0d", i, tbl[i].len, tbl[i].np);
      run_pkt(tbl[i].len, tbl[i].np, tbl[i].gap, 0);
      check_pkt(tbl[i].exp_n, tbl[i].exp_err);
    end

    // Back-to-back pages: header right after sop, 16 contiguous words
    do_reset();
    ctx = "contiguous";
    run_pkt(15, 2, 0, 0);
    check_pkt(16, 0);
    chk("hdr_after_sop", vcyc_q[base_w] - sop_cyc_q[base_s], 1);
    chk("vld_span", vcyc_q[base_w + 15] - vcyc_q[base_w], 15);

    // Second page late: bubble, no early eop
    do_reset();
    ctx = "late_page";
    snap();
    gen_pages(15, 2);
    ready = 1'b1;
    send_page(pg_q[0], 1'b0);
    n = 0;
    while ((got_q.size() - base_w) < 8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("words_before_page2", got_q.size() - base_w, 8);
    chk("no_eop_before_page2", eop_pos_q.size() - base_e, 0);
    send_page(pg_q[1], 1'b1);
    wait_done();
    check_pkt(16, 0);
    span = vcyc_q[got_q.size() - 1] - vcyc_q[base_w] + 1 - 16;
    chk("bubble_cycles_4to7", int'(span >= 4 && span <= 7), 1);

    // Page held while ready is low
    do_reset();
    ctx = "ready_hold";
    snap();
    gen_pages(3, 1);
    ready = 1'b0;
    send_page(pg_q[0], 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("no_sop_while_not_ready", sop_cyc_q.size() - base_s, 0);
    raise_cyc = cyc;
    ready = 1'b1;
    wait_done();
    check_pkt(4, 0);
    chk("sop_latency", (sop_cyc_q.size() > base_s) ? sop_cyc_q[base_s] - raise_cyc : -1, 1);
    chk("hdr_latency", (got_q.size() > base_w) ? vcyc_q[base_w] - raise_cyc : -1, 2);

    // Reset in the middle of a packet
    do_reset();
    ctx = "reset_mid";
    snap();
    gen_pages(15, 2);
    ready = 1'b1;
    send_page(pg_q[0], 1'b0);
    send_page(pg_q[1], 1'b1);
    n = 0;
    while ((got_q.size() - base_w) < 11 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_word10", got_q.size() - base_w, 11);
    #1 rst_n = 1'b0;
    #1;
    chk("rd_sop", int'(rd_sop), 0);
    chk("rd_vld", int'(rd_vld), 0);
    chk("rd_eop", int'(rd_eop), 0);
    chk("rd_data", int'(rd_data), 0);
    chk("page_rdy", int'(page_rdy), 0);
    chk("len_err", int'(len_err), 0);
    chk("no_eop_emitted", eop_pos_q.size() - base_e, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    ctx = "after_reset_len0";
    run_pkt(0, 1, 0, 0);
    check_pkt(1, 0);
    chk("single_word_eop_hdr_after_sop", vcyc_q[base_w] - sop_cyc_q[base_s], 1);

    // Randomized packets against the framing model (len_err is sticky)
    do_reset();
    err_model = 0;
    for (int k = 0; k < 30; k++) begin
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 511))
                                        : int'($urandom_range(0, 40));
      n_ok = (len + 8) / 8;
      mode = $urandom_range(0, 4);
      if (mode == 0)                 np = n_ok + 1;
      else if (mode == 1 && n_ok > 1) np = n_ok - 1;
      else                           np = n_ok;
      exp_n = (len + 1 < 8 * np) ? len + 1 : 8 * np;
      if (np != n_ok) err_model = 1;
      ctx = $sformatf("rnd%0d_len%0d_np%0d", k, len, np);
      run_pkt(len, np, 3, $urandom_range(0, 3));
      check_pkt(exp_n, err_model);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
